// File: rtl/mesm6_gpio_irq_if.sv
// mesm6_gpio_irq_if
// Data-bus connection between the MESM-6 bus side (master) and the GPIO
// peripheral slot (slave).
//   i_addr  [14:0] register address, only [2:0] used by the GPIO block
//   i_read         read request, level, held until o_done
//   i_write        write request, level, held until o_done
//   i_data  [47:0] write data
//   o_data  [47:0] read data, valid while o_done is high, 0 otherwise
//   o_done         one-cycle completion pulse
interface mesm6_gpio_irq_if;
    logic [14:0] i_addr;
    logic        i_read;
    logic        i_write;
    logic [47:0] i_data;
    logic [47:0] o_data;
    logic        o_done;

    modport master (
        output i_addr, i_read, i_write, i_data,
        input  o_data, o_done
    );

    modport slave (
        input  i_addr, i_read, i_write, i_data,
        output o_data, o_done
    );
endinterface

// File: rtl/mesm6_gpio_irq.sv
// mesm6_gpio_irq
// GPIO peripheral for the MESM-6 data bus: WIDTH synchronised (and optionally
// debounced) inputs, WIDTH outputs with set/clear access, and per-bit
// rise/fall edge interrupts with mask and write-1-to-clear pending bits.
//
// Optional feature macro: MESM6_GPIO_DEBOUNCE_EN
//   defined   : prescaler tick every DEBOUNCE_CYCLES clocks, 3-sample debounce
//   undefined : debounced state is the 2-flop synchroniser output
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   bus       mesm6_gpio_irq_if.slave (addr/read/write/data/done)
//   irq       level interrupt, |(pend & mask), registered
//   gpio_in   raw asynchronous input pins
//   gpio_out  output register
//
// Register map (i_addr[2:0]): 0 IN(ro), 1 OUT, 2 SET(wo), 3 CLR(wo),
//   4 MASK, 5 RISE, 6 FALL, 7 PEND(W1C). Bus bits above WIDTH read 0.
module mesm6_gpio_irq #(
    parameter int               WIDTH           = 48,
    parameter int               DEBOUNCE_CYCLES = 10000,
    parameter int               CNT_W           = 14,
    parameter logic [WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mesm6_gpio_irq_if.slave      bus,
    output logic                 irq,
    input  logic [WIDTH-1:0]     gpio_in,
    output logic [WIDTH-1:0]     gpio_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_wr_en;
    logic             w_rd_en;
    logic             r_done;
    logic [47:0]      r_rdata;
    logic [WIDTH-1:0] w_rd_val;
    logic [47:0]      w_rd_bus;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_w1c;
    logic [2:0]       w_addr;

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_pend;
    logic             r_irq;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_db;
    logic [WIDTH-1:0] r_db_d;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    // Address bits above the register offset and data bits above WIDTH are
    // deliberately ignored.
    logic             w_unused_bus;
    assign w_unused_bus = ^{bus.i_addr[14:3], bus.i_data};

    assign w_addr  = bus.i_addr[2:0];
    assign w_wdata = bus.i_data[WIDTH-1:0];

    // Bus FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus FSM next state; a request is only accepted in IDLE, so a held
    // request cannot execute twice. Write beats read when both are high.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_write) begin
                    w_wr_en     = 1'b1;
                    w_state_nxt = ST_ACK;
                end else if (bus.i_read) begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = ST_ACK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACK:  w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (!bus.i_read && !bus.i_write) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Read multiplexer, zero-extended to the 48-bit bus.
    always_comb begin
        w_rd_val = '0;
        w_rd_bus = 48'd0;
        case (w_addr)
            3'd0:    w_rd_val = w_db;
            3'd1:    w_rd_val = r_out;
            3'd4:    w_rd_val = r_mask;
            3'd5:    w_rd_val = r_rise;
            3'd6:    w_rd_val = r_fall;
            3'd7:    w_rd_val = r_pend;
            default: w_rd_val = '0;
        endcase
        w_rd_bus[WIDTH-1:0] = w_rd_val;
    end

    // Registered bus response: done and read data live only in the ACK cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done  <= 1'b0;
            r_rdata <= 48'd0;
        end else begin
            r_done  <= w_wr_en | w_rd_en;
            r_rdata <= w_rd_en ? w_rd_bus : 48'd0;
        end
    end

    // Writable control registers, updated on the accepting edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out  <= OUT_RESET;
            r_mask <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else if (w_wr_en) begin
            case (w_addr)
                3'd1:    r_out  <= w_wdata;
                3'd2:    r_out  <= r_out | w_wdata;
                3'd3:    r_out  <= r_out & ~w_wdata;
                3'd4:    r_mask <= w_wdata;
                3'd5:    r_rise <= w_wdata;
                3'd6:    r_fall <= w_wdata;
                default: r_out  <= r_out;
            endcase
        end
    end

    assign w_w1c = (w_wr_en && (w_addr == 3'd7)) ? w_wdata : '0;

    // Two-flop synchroniser for the raw pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef MESM6_GPIO_DEBOUNCE_EN
    logic [CNT_W-1:0] r_presc;
    logic             w_tick;
    logic [WIDTH-1:0] r_h0;
    logic [WIDTH-1:0] r_h1;
    logic [WIDTH-1:0] r_db;

    assign w_tick = (r_presc == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Debounce prescaler, wraps at DEBOUNCE_CYCLES-1 and ticks on the wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + CNT_W'(1);
        end
    end

    // Three-sample history: two stored samples plus the one taken this tick.
    // The debounced bit follows only when all three agree, otherwise holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h0 <= '0;
            r_h1 <= '0;
            r_db <= '0;
        end else if (w_tick) begin
            r_h0 <= r_sync2;
            r_h1 <= r_h0;
            r_db <= (r_sync2 & r_h0 & r_h1) | (r_db & (r_sync2 | r_h0 | r_h1));
        end
    end

    assign w_db = r_db;
`else
    localparam int unused_debounce_cfg = DEBOUNCE_CYCLES + CNT_W;
    assign w_db = r_sync2;
`endif

    // Previous debounced value for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db_d <= '0;
        end else begin
            r_db_d <= w_db;
        end
    end

    assign w_rise = w_db & ~r_db_d;
    assign w_fall = ~w_db & r_db_d;

    // Pending bits: W1C first, then new edges OR-ed in so a coincident edge wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_w1c) | (w_rise & r_rise) | (w_fall & r_fall);
        end
    end

    // Registered interrupt request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_pend & r_mask);
        end
    end

    assign bus.o_done = r_done;
    assign bus.o_data = r_rdata;
    assign irq        = r_irq;
    assign gpio_out   = r_out;

endmodule

// File: tb/tb_mesm6_gpio_irq.sv
// tb_mesm6_gpio_irq
// Directed self-checking bench for mesm6_gpio_irq with WIDTH=8,
// DEBOUNCE_CYCLES=4, OUT_RESET=0x05. Works for both builds of
// MESM6_GPIO_DEBOUNCE_EN; timing-exact steps apply to the default build.
module tb_mesm6_gpio_irq;
    localparam int W  = 8;
    localparam int DC = 4;

    logic         clk;
    logic         reset_n;
    logic         irq;
    logic [W-1:0] gpio_in;
    logic [W-1:0] gpio_out;
    int           n_vec;
    int           n_miss;
    int           cyc;
    int           dones;

    mesm6_gpio_irq_if bus_if ();

    mesm6_gpio_irq #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (3),
        .OUT_RESET       (8'h05)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if),
        .irq      (irq),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one bus request at the current negedge, wait (bounded) for o_done,
    // release, and return once the FSM is back in IDLE.
    task automatic bus_xfer(input logic wr, input logic [2:0] addr, input logic [47:0] wdata,
                            input string tag, output logic [47:0] rdata);
        bit seen;
        seen  = 1'b0;
        rdata = 48'd0;
        bus_if.i_addr  = {12'd0, addr};
        bus_if.i_data  = wdata;
        bus_if.i_write = wr;
        bus_if.i_read  = ~wr;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_if.o_done) begin
                seen  = 1'b1;
                rdata = bus_if.o_data;
                break;
            end
        end
        check({tag, "_done"}, 48'(seen), 48'd1);
        bus_if.i_write = 1'b0;
        bus_if.i_read  = 1'b0;
        @(negedge clk);
        check({tag, "_odata_idle"}, bus_if.o_data, 48'd0);
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic [2:0] addr, input logic [47:0] wdata, input string tag);
        logic [47:0] d;
        bus_xfer(1'b1, addr, wdata, tag, d);
    endtask

    task automatic bus_rd(input logic [2:0] addr, input logic [47:0] exp, input string tag);
        logic [47:0] d;
        bus_xfer(1'b0, addr, 48'd0, tag, d);
        check(tag, d, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec          = 0;
        n_miss         = 0;
        reset_n        = 1'b0;
        gpio_in        = 8'h00;
        bus_if.i_addr  = 15'd0;
        bus_if.i_data  = 48'd0;
        bus_if.i_read  = 1'b0;
        bus_if.i_write = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_gpio_out", 48'(gpio_out), 48'h05);
        check("rst_irq", 48'(irq), 48'd0);
        check("rst_done", 48'(bus_if.o_done), 48'd0);
        check("rst_odata", bus_if.o_data, 48'd0);
        reset_n = 1'b1;
        @(negedge clk);
        bus_rd(3'd1, 48'h000000000005, "rd_out_rst");
        bus_rd(3'd4, 48'd0, "rd_mask_rst");
        bus_rd(3'd7, 48'd0, "rd_pend_rst");

        // OUT / SET / CLR
        bus_wr(3'd1, 48'hF0, "wr_out");
        bus_wr(3'd2, 48'h0F, "wr_set");
        bus_wr(3'd3, 48'h30, "wr_clr");
        check("out_after_setclr", 48'(gpio_out), 48'hCF);
        bus_rd(3'd1, 48'hCF, "rd_out_cf");
        bus_rd(3'd2, 48'd0, "rd_set_zero");
        bus_rd(3'd3, 48'd0, "rd_clr_zero");

        // Request held well past done: exactly one completion
        bus_if.i_addr = 15'd1;
        bus_if.i_read = 1'b1;
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus_if.o_done) dones++;
        end
        check("held_single_done", 48'(dones), 48'd1);
        bus_if.i_read = 1'b0;
        repeat (2) @(negedge clk);

        // Bits above WIDTH ignored
        bus_wr(3'd1, 48'hFFFF, "wr_out_wide");
        check("out_wide", 48'(gpio_out), 48'hFF);
        bus_rd(3'd1, 48'hFF, "rd_out_wide");
        bus_wr(3'd1, 48'h00, "wr_out_zero");

        // Rise interrupt on bit 3, masked in
        bus_wr(3'd5, 48'h08, "wr_rise");
        bus_wr(3'd4, 48'h08, "wr_mask");
        gpio_in[3] = 1'b1;
        cyc = 0;
        while (!irq && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
`ifdef MESM6_GPIO_DEBOUNCE_EN
        check("irq_rise_within_bound", 48'(cyc <= 20), 48'd1);
`else
        // sync1, sync2 (= IN), pend, irq
        check("irq_rise_latency", 48'(cyc), 48'd4);
`endif
        bus_rd(3'd7, 48'h08, "rd_pend_rise");
        bus_rd(3'd0, 48'h08, "rd_in_bit3");
        bus_wr(3'd7, 48'h08, "w1c_bit3");
        check("irq_after_w1c", 48'(irq), 48'd0);
        bus_rd(3'd7, 48'd0, "rd_pend_cleared");

        // Masked: pend still sets, irq stays low
        bus_wr(3'd4, 48'h00, "wr_mask_off");
        gpio_in[3] = 1'b0;
        repeat (25) @(negedge clk);
        gpio_in[3] = 1'b1;
        repeat (25) @(negedge clk);
        bus_rd(3'd7, 48'h08, "rd_pend_masked");
        check("irq_masked", 48'(irq), 48'd0);
        bus_wr(3'd7, 48'h08, "w1c_masked");

`ifdef MESM6_GPIO_DEBOUNCE_EN
        // One-tick glitch low on bit 3 must be filtered out
        bus_wr(3'd6, 48'h08, "wr_fall_b3");
        gpio_in[3] = 1'b0;
        repeat (DC) @(negedge clk);
        gpio_in[3] = 1'b1;
        repeat (25) @(negedge clk);
        bus_rd(3'd0, 48'h08, "rd_in_glitch");
        bus_rd(3'd7, 48'd0, "rd_pend_glitch");
        bus_wr(3'd6, 48'h00, "wr_fall_off");
`endif

        // Fall on bit 0 coincident with its W1C: set wins
        bus_wr(3'd6, 48'h01, "wr_fall_b0");
        gpio_in[0] = 1'b1;
        repeat (25) @(negedge clk);
        bus_rd(3'd7, 48'd0, "rd_pend_no_rise_b0");
`ifdef MESM6_GPIO_DEBOUNCE_EN
        gpio_in[0] = 1'b0;
        repeat (25) @(negedge clk);
        bus_rd(3'd7, 48'h01, "rd_pend_fall_b0");
`else
        gpio_in[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Write accepted on the same edge the fall edge sets pend[0]
        bus_wr(3'd7, 48'h01, "w1c_race");
        bus_rd(3'd7, 48'h01, "rd_pend_race");
`endif

        // Reset during ACK
        bus_wr(3'd4, 48'h01, "wr_mask_b0");
        check("irq_before_rst", 48'(irq), 48'd1);
        bus_if.i_addr  = 15'd1;
        bus_if.i_data  = 48'h3C;
        bus_if.i_write = 1'b1;
        @(negedge clk);
        check("ack_before_rst", 48'(bus_if.o_done), 48'd1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_done", 48'(bus_if.o_done), 48'd0);
        check("rst_mid_out", 48'(gpio_out), 48'h05);
        check("rst_mid_irq", 48'(irq), 48'd0);
        check("rst_mid_odata", bus_if.o_data, 48'd0);
        bus_if.i_write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_rd(3'd1, 48'h05, "rd_out_post_rst");
        bus_rd(3'd4, 48'd0, "rd_mask_post_rst");
        bus_rd(3'd7, 48'd0, "rd_pend_post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
